// File: rtl/usb_fs_in_rr_arb_if.sv
// Endpoint/PE side bundle of the IN round-robin arbiter.
// master = arbiter, slave = endpoints plus IN protocol engine.
interface usb_fs_in_rr_arb_if #(
  parameter int unsigned NUM_IN_EPS = 1
);
  logic [NUM_IN_EPS-1:0]   in_ep_req;
  logic [NUM_IN_EPS*8-1:0] in_ep_data;
  logic                    pe_busy;
  logic [NUM_IN_EPS-1:0]   in_ep_grant;
  logic [7:0]              arb_in_ep_data;
  logic                    grant_valid;
  logic [3:0]              grant_idx;

  modport master (
    input  in_ep_req, in_ep_data, pe_busy,
    output in_ep_grant, arb_in_ep_data, grant_valid, grant_idx
  );

  modport slave (
    output in_ep_req, in_ep_data, pe_busy,
    input  in_ep_grant, arb_in_ep_data, grant_valid, grant_idx
  );
endinterface

// File: rtl/usb_fs_in_rr_arb.sv
// Registered round-robin arbiter sharing the IN PE data path between IN endpoints.
// Grants freeze while the PE is busy; an optional hold timeout forces rotation.
module usb_fs_in_rr_arb #(
  parameter int unsigned NUM_IN_EPS = 1,
  parameter int unsigned MAX_HOLD   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  usb_fs_in_rr_arb_if.master bus
);
  localparam int unsigned      N        = NUM_IN_EPS;
  localparam int unsigned      IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [N-1:0]          req_hi;
  logic [N-1:0]          req_cand;
  logic [N-1:0]          sel_onehot;
  logic [N:0][IDX_W-1:0] idx_chain;
  logic [N:0][7:0]       data_acc;
  logic [IDX_W-1:0]      sel_idx;
  logic                  owner_req;
  logic                  timeout;

  // Requesters at or above ptr win first; otherwise wrap around to the lowest index.
  assign req_hi     = bus.in_ep_req & ~((N'(1) << ptr_q) - N'(1));
  assign req_cand   = (|req_hi) ? req_hi : bus.in_ep_req;
  assign sel_onehot = req_cand & (~req_cand + N'(1));

  assign idx_chain[N] = '0;
  assign data_acc[0]  = '0;
  for (genvar g = 0; g < N; g++) begin : g_ep
    assign idx_chain[g]  = req_cand[g] ? IDX_W'(g) : idx_chain[g+1];
    assign data_acc[g+1] = data_acc[g] | (bus.in_ep_data[8*g +: 8] & {8{grant_q[g]}});
  end
  assign sel_idx = idx_chain[0];

  assign owner_req = |(bus.in_ep_req & grant_q);
  assign timeout   = HOLD_EN && (cnt_q >= HOLD_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.in_ep_req) begin
          state_d = GRANT;
          grant_d = sel_onehot;
          idx_d   = sel_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // Release (voluntary or forced) is only allowed between PE transactions.
        if (!bus.pe_busy && (!owner_req || timeout)) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.in_ep_grant    = grant_q;
  assign bus.grant_valid    = |grant_q;
  assign bus.grant_idx      = idx_q;
  assign bus.arb_in_ep_data = data_acc[N];

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Bench for usb_fs_in_rr_arb: three configurations (N=4, N=4 with MAX_HOLD=8, N=3)
// checked each cycle against an owner/pointer reference model plus directed scenarios.
module tb_usb_fs_in_rr_arb;
  localparam int NDUT = 3;

  typedef struct {
    int n;
    int max_hold;
    int owner;   // -1 when nobody holds the grant
    int ptr;
    int held;    // granted cycles so far, including the current one
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_v  [NDUT];
  logic        busy_v [NDUT];
  logic [31:0] dat_v  [NDUT];
  mdl_t        mdl    [NDUT];
  string       nm     [NDUT] = '{"a", "b", "c"};

  int checks = 0;
  int passed = 0;

  usb_fs_in_rr_arb_if #(.NUM_IN_EPS(4)) if_a ();
  usb_fs_in_rr_arb_if #(.NUM_IN_EPS(4)) if_b ();
  usb_fs_in_rr_arb_if #(.NUM_IN_EPS(3)) if_c ();

  usb_fs_in_rr_arb #(.NUM_IN_EPS(4), .MAX_HOLD(0), .CNT_W(16)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  usb_fs_in_rr_arb #(.NUM_IN_EPS(4), .MAX_HOLD(8), .CNT_W(16)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  usb_fs_in_rr_arb #(.NUM_IN_EPS(3), .MAX_HOLD(0), .CNT_W(16)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  assign if_a.in_ep_req  = req_v[0];
  assign if_a.in_ep_data = dat_v[0];
  assign if_a.pe_busy    = busy_v[0];
  assign if_b.in_ep_req  = req_v[1];
  assign if_b.in_ep_data = dat_v[1];
  assign if_b.pe_busy    = busy_v[1];
  assign if_c.in_ep_req  = req_v[2][2:0];
  assign if_c.in_ep_data = dat_v[2][23:0];
  assign if_c.pe_busy    = busy_v[2];

  // Reference: one owner at a time, fair scan from ptr, release only when PE idle.
  function automatic mdl_t step(input mdl_t m, input logic [3:0] req, input logic busy, input logic rst);
    mdl_t r;
    logic [3:0] rs;
    bit found;
    bit expired;
    r = m;
    found = 0;
    if (rst) begin
      r.owner = -1; r.ptr = 0; r.held = 0;
    end else if (m.owner < 0) begin
      for (int k = 0; k < m.n; k++) begin
        rs = req >> ((m.ptr + k) % m.n);
        if (!found && rs[0]) begin
          found = 1; r.owner = (m.ptr + k) % m.n; r.held = 1;
        end
      end
    end else begin
      rs = req >> m.owner;
      expired = (m.max_hold != 0) && (m.held >= m.max_hold);
      if (!busy && (!rs[0] || expired)) begin
        r.owner = -1; r.ptr = (m.owner + 1) % m.n; r.held = 0;
      end else begin
        r.held = m.held + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_grant(input mdl_t m);
    return (m.owner < 0) ? 4'h0 : 4'(1 << m.owner);
  endfunction

  function automatic logic [7:0] exp_data(input mdl_t m, input logic [31:0] dat);
    if (m.owner < 0) return 8'h00;
    return 8'(dat >> (8 * m.owner));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic get_obs(input int d, output logic [3:0] g, output logic v,
                         output logic [3:0] i, output logic [7:0] x);
    case (d)
      0: begin g = if_a.in_ep_grant; v = if_a.grant_valid; i = if_a.grant_idx; x = if_a.arb_in_ep_data; end
      1: begin g = if_b.in_ep_grant; v = if_b.grant_valid; i = if_b.grant_idx; x = if_b.arb_in_ep_data; end
      default: begin g = {1'b0, if_c.in_ep_grant}; v = if_c.grant_valid; i = if_c.grant_idx; x = if_c.arb_in_ep_data; end
    endcase
  endtask

  task automatic check_all(input bit data_only);
    logic [3:0] g; logic v; logic [3:0] i; logic [7:0] x;
    for (int d = 0; d < NDUT; d++) begin
      get_obs(d, g, v, i, x);
      chk({nm[d], ".data"}, 32'(x), 32'(exp_data(mdl[d], dat_v[d])));
      if (!data_only) begin
        chk({nm[d], ".grant"}, 32'(g), 32'(exp_grant(mdl[d])));
        chk({nm[d], ".valid"}, 32'(v), 32'(mdl[d].owner >= 0));
        chk({nm[d], ".idx"}, 32'(i), (mdl[d].owner < 0) ? 32'd0 : 32'(mdl[d].owner));
        chk({nm[d], ".onehot"}, 32'($onehot0(g)), 32'd1);
      end
    end
  endtask

  task automatic cycle();
    mdl_t nx [NDUT];
    for (int d = 0; d < NDUT; d++) nx[d] = step(mdl[d], req_v[d], busy_v[d], reset);
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) mdl[d] = nx[d];
    @(negedge clk);
    check_all(1'b0);
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      req_v[d] = '0; busy_v[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int order[$];
  int switches;
  int hold_cnt;
  logic prev_v;
  logic [3:0] prev_i;
  logic [3:0] exp_g;
  int p;

  initial begin
    mdl[0] = '{4, 0, -1, 0, 0};
    mdl[1] = '{4, 8, -1, 0, 0};
    mdl[2] = '{3, 0, -1, 0, 0};
    idle_all();
    for (int d = 0; d < NDUT; d++) dat_v[d] = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Single requester ep2: one-cycle latency, byte muxed through.
    dat_v[0] = 32'h11A5_2233;
    req_v[0] = 4'b0100;
    cycle();
    chk("t1_grant", 32'(if_a.in_ep_grant), 32'h4);
    chk("t1_idx", 32'(if_a.grant_idx), 32'd2);
    chk("t1_data", 32'(if_a.arb_in_ep_data), 32'hA5);
    req_v[0] = 4'b0000;
    cycle();
    cycle();

    // All request; owner drops for one cycle after 3 granted cycles.
    do_reset();
    req_v[0] = 4'hF;
    switches = 0; hold_cnt = 0; prev_v = 1'b0; prev_i = '0;
    for (int k = 0; k < 40 && order.size() < 5; k++) begin
      req_v[0] = (hold_cnt == 3) ? (4'hF & ~(4'(1) << if_a.grant_idx)) : 4'hF;
      cycle();
      if (if_a.grant_valid && !prev_v) order.push_back(int'(if_a.grant_idx));
      if (if_a.grant_valid && prev_v && if_a.grant_idx != prev_i) switches++;
      hold_cnt = if_a.grant_valid ? hold_cnt + 1 : 0;
      prev_v = if_a.grant_valid;
      prev_i = if_a.grant_idx;
    end
    chk("t2_ngrants", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size(); k++) chk("t2_order", 32'(order[k]), 32'(k % 4));
    chk("t2_switches", 32'(switches), 32'd0);
    req_v[0] = '0;
    cycle();
    cycle();

    // Owner ep1 drops req while PE busy: grant frozen, then released, ptr=2.
    do_reset();
    req_v[0] = 4'b0010;
    cycle();
    chk("t3_grant", 32'(if_a.in_ep_grant), 32'h2);
    req_v[0] = 4'b0000;
    busy_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold", 32'(if_a.in_ep_grant), 32'h2);
    end
    busy_v[0] = 1'b0;
    cycle();
    chk("t3_release", 32'(if_a.in_ep_grant), 32'h0);
    req_v[0] = 4'hF;
    cycle();
    chk("t3_ptr", 32'(if_a.grant_idx), 32'd2);
    req_v[0] = '0;
    cycle();
    cycle();

    // MAX_HOLD=8 with two constant requesters: 8 on, 1 gap, alternate.
    do_reset();
    req_v[1] = 4'b0011;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      p = (k - 1) % 18;
      exp_g = (p < 8) ? 4'b0001 : ((p == 8 || p == 17) ? 4'b0000 : 4'b0010);
      chk("t4_timeout_seq", 32'(if_b.in_ep_grant), 32'(exp_g));
    end
    req_v[1] = '0;
    cycle();
    cycle();

    // MAX_HOLD=8 reached with PE busy: deferred until busy drops.
    do_reset();
    req_v[1] = 4'b0001;
    cycle();
    busy_v[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t5_deferred", 32'(if_b.in_ep_grant), 32'h1);
    end
    busy_v[1] = 1'b0;
    cycle();
    chk("t5_forced", 32'(if_b.in_ep_grant), 32'h0);
    cycle();
    chk("t5_regrant", 32'(if_b.in_ep_grant), 32'h1);
    req_v[1] = '0;
    cycle();
    cycle();

    // N=3: ptr wraps 2->0; reset mid-grant drops it; then 3'b110 grants ep1.
    do_reset();
    req_v[2] = 4'b0100;
    cycle();
    chk("t6_ep2", 32'(if_c.in_ep_grant), 32'h4);
    req_v[2] = 4'b0000;
    cycle();
    req_v[2] = 4'b0111;
    cycle();
    chk("t6_wrap", 32'(if_c.in_ep_grant), 32'h1);
    reset = 1'b1;
    cycle();
    chk("t6_reset", 32'(if_c.in_ep_grant), 32'h0);
    reset = 1'b0;
    req_v[2] = 4'b0110;
    cycle();
    chk("t6_after_reset", 32'(if_c.in_ep_grant), 32'h2);
    idle_all();
    cycle();
    cycle();

    // Random traffic on all three configurations.
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < NDUT; d++) begin
        req_v[d]  = 4'($urandom) & ((d == 2) ? 4'h7 : 4'hF);
        busy_v[d] = ($urandom_range(0, 3) == 0);
        dat_v[d]  = $urandom;
      end
      reset = ($urandom_range(0, 59) == 0);
      #1;
      check_all(1'b1);
      cycle();
    end
    reset = 1'b0;
    idle_all();
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
